// File: rtl/am_demod_tdm_ctrl.sv
// AM magnitude engine: sqrt(I^2 + Q^2) using one shared multiplier and a bit-serial restoring root.
// Define AMDEMOD_ROUND_EN to round the root to nearest instead of truncating.
module am_demod_tdm_ctrl #(
  parameter int INPUT_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [INPUT_WIDTH-1:0] inphase,
  input  logic signed [INPUT_WIDTH-1:0] quadrature,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [INPUT_WIDTH-1:0] amdemod_out,
  output logic                          busy
);

  localparam int W  = INPUT_WIDTH;
  localparam int RW = W + 2;
  localparam int IW = $clog2(W);

  typedef enum logic [2:0] {IDLE, MUL_I, MUL_Q, SQRT, DONE} state_t;

  state_t state, next_state;

  logic signed [W-1:0]   i_reg;
  logic signed [W-1:0]   q_reg;
  logic signed [W-1:0]   mult_op;
  logic signed [2*W-1:0] mult_ext;
  logic signed [2*W-1:0] product;
  logic [2*W-1:0]        acc;
  logic [W-1:0]          root;
  logic [W-1:0]          next_root;
  logic [W-1:0]          final_root;
  logic [RW-1:0]         rem;
  logic [RW-1:0]         next_rem;
  logic [RW-1:0]         sub;
  logic [RW+1:0]         shifted;
  logic                  trial_ok;
  logic [IW-1:0]         iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = MUL_I;
      MUL_I:   next_state = MUL_Q;
      MUL_Q:   next_state = SQRT;
      SQRT:    if (iter == '0) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // The single multiplier squares I in MUL_I and Q in MUL_Q.
  always_comb begin
    mult_op  = (state == MUL_Q) ? q_reg : i_reg;
    mult_ext = {{W{mult_op[W-1]}}, mult_op};
    product  = mult_ext * mult_ext;
  end

  // One restoring step: bring down the next two radicand bits and try subtracting 4*root+1.
  always_comb begin
    shifted   = {rem, acc[2*W-1 -: 2]};
    sub       = {root, 2'b01};
    trial_ok  = (shifted >= {2'b00, sub});
    next_rem  = trial_ok ? (shifted[RW-1:0] - sub) : shifted[RW-1:0];
    next_root = {root[W-2:0], trial_ok};
`ifdef AMDEMOD_ROUND_EN
    final_root = next_root;
    if ((next_rem > {2'b00, next_root}) && !(&next_root))
      final_root = next_root + W'(1);
`else
    final_root = next_root;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg       <= '0;
      q_reg       <= '0;
      acc         <= '0;
      root        <= '0;
      rem         <= '0;
      iter        <= '0;
      out_valid   <= 1'b0;
      amdemod_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            i_reg <= inphase;
            q_reg <= quadrature;
          end
        end
        MUL_I: acc <= $unsigned(product);
        MUL_Q: begin
          acc  <= acc + $unsigned(product);
          root <= '0;
          rem  <= '0;
          iter <= IW'(W - 1);
        end
        SQRT: begin
          acc  <= acc << 2;
          rem  <= next_rem;
          root <= next_root;
          iter <= iter - IW'(1);
          if (iter == '0) begin
            out_valid   <= 1'b1;
            amdemod_out <= final_root;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_am_demod_tdm_ctrl.sv
// Scoreboard bench for am_demod_tdm_ctrl: stimulus pushes expected magnitudes, a monitor pops and compares.
// Build with AMDEMOD_ROUND_EN defined to check the rounding variant.
module tb_am_demod_tdm_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] inphase;
  logic signed [11:0] quadrature;
  logic               out_valid;
  logic               out_ready;
  logic [11:0]        amdemod_out;
  logic               busy;

  int checks = 0;
  int passes = 0;
  int exp_q[$];

`ifdef AMDEMOD_ROUND_EN
  localparam int EXP_2_2 = 3;
`else
  localparam int EXP_2_2 = 2;
`endif

  am_demod_tdm_ctrl #(.INPUT_WIDTH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inphase     (inphase),
    .quadrature  (quadrature),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .amdemod_out (amdemod_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_mag(input int i, input int q);
    int n, r;
    n = i * i + q * q;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
`ifdef AMDEMOD_ROUND_EN
    if ((n - r * r > r) && (r < 4095)) r++;
`endif
    return r;
  endfunction

  task automatic checkSignal(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic checkOutput();
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL unexpected_output: got %0d, expected no output at %0t", amdemod_out, $time);
    end else begin
      e = exp_q.pop_front();
      if (int'(amdemod_out) == e) passes++;
      else $display("[TB] FAIL magnitude: got %0d, expected %0d at %0t", amdemod_out, e, $time);
    end
  endtask

  // Drives one pair and returns #1 after the accepting edge; optionally leaves in_valid high.
  task automatic applyStimulus(input int i, input int q, input int expected, input bit push, input bit hold_valid);
    int n;
    n = 0;
    inphase    = 12'(i);
    quadrature = 12'(q);
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL handshake_timeout: in_ready got 0, expected 1 at %0t", $time);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(expected);
      #1;
      if (!hold_valid) in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkSignal(name, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) checkOutput();
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int di[5];
    int dq[5];
    int de[5];
    logic signed [11:0] ri, rq;

    di = '{-2048, 0, 2047, 2, 1};
    dq = '{-2048, 0, 0, 2, 1};
    de = '{2896, 0, 2047, EXP_2_2, 1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    inphase    = '0;
    quadrature = '0;
    #12;
    checkSignal("reset_in_ready", int'(in_ready), 1);
    checkSignal("reset_out_valid", int'(out_valid), 0);
    checkSignal("reset_busy", int'(busy), 0);
    checkSignal("reset_amdemod_out", int'(amdemod_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First transaction: latency, pulse width and return to idle.
    applyStimulus(3, 4, 5, 1'b1, 1'b0);
    checkSignal("busy_after_handshake", int'(busy), 1);
    checkSignal("in_ready_after_handshake", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkSignal("latency", n, 14);
    @(posedge clk);
    #1;
    checkSignal("pulse_width", int'(out_valid), 0);
    checkSignal("in_ready_return", int'(in_ready), 1);

    for (int k = 0; k < 5; k++) applyStimulus(di[k], dq[k], de[k], 1'b1, 1'b0);
    waitDrain("directed_drain");

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(2047, 0, 2047, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkSignal("bp_valid_rise", int'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      inphase    = 12'(c + 7);
      quadrature = 12'(c + 9);
      in_valid   = (c % 2 == 0);
      @(posedge clk);
      #1;
      checkSignal("bp_out_valid_hold", int'(out_valid), 1);
      checkSignal("bp_amdemod_hold", int'(amdemod_out), 2047);
      checkSignal("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkSignal("bp_release_valid", int'(out_valid), 0);
    checkSignal("bp_release_in_ready", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    checkSignal("bp_no_latched_input", int'(busy), 0);

    // Asynchronous reset during SQRT discards the partial result.
    applyStimulus(100, 100, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkSignal("abort_out_valid", int'(out_valid), 0);
    checkSignal("abort_in_ready", int'(in_ready), 1);
    checkSignal("abort_busy", int'(busy), 0);
    checkSignal("abort_amdemod_out", int'(amdemod_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    applyStimulus(6, 8, 10, 1'b1, 1'b0);
    waitDrain("after_reset_drain");

    // Back-to-back stream with in_valid held high.
    for (int k = 0; k < 20; k++) begin
      ri = 12'($urandom);
      rq = 12'($urandom);
      applyStimulus(int'(ri), int'(rq), ref_mag(int'(ri), int'(rq)), 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    waitDrain("stream_drain");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
